reaction_controller: RTL and testbench
======================================

# reaction_controller

Sequencing FSM for the reaction-time benchmark. It drives the reaction datapath's start and load strobes: the down-count random delay, the up-count score timer and the score-load edge. It also detects false starts and timeouts, counts rounds and selects the display screen. It sits between the debounced player pushbutton and the reaction datapath, on the 50 MHz system clock.

## Interface
Parameters:
- ARM_CYCLES, 50000: cycles oStart_down_count is held high in ARM; must be ≥ one 1 kHz tick so the datapath captures it; range 1..65535.
- HOLD_CYCLES, 25000000: minimum cycles RESULT/EARLY are shown before a press is accepted; range 1..2^25-1.
- TIMEOUT_MS, 2000: up-count value at which GO times out; range 1..4095.
- NUM_ROUNDS, 5: rounds per session; range 1..7.

Ports:
- clk  in  1  system clock, 50 MHz
- iReset  in  1  synchronous, active-high reset
- iButton  in  1  player button, active high, asynchronous to clk
- iCountComplete  in  1  datapath random-delay-expired flag (level)
- iUpCount  in  12  datapath up-count, ms since GO
- oStart_down_count  out  1  reloads the random delay counter while high
- oStart_up_count  out  1  holds the score timer at 0 while high
- oLoad_score  out  1  one-cycle pulse; its rising edge latches the score
- oScreen  out  2  0 = idle/instructions, 1 = wait (red), 2 = go (green), 3 = result
- oEarly  out  1  high in EARLY (false start)
- oTimeout  out  1  high in RESULT when the round timed out
- oRound  out  3  completed rounds this session
- oDone  out  1  high in DONE

## Operation
- Button path: 2-flop synchronizer, then a rising-edge detector (press = sync2 & ~prev). One press equals one edge; holding the button does not repeat.
- iCountComplete edge: a prev register (reset value 1) feeds `cc_rise = iCountComplete & ~prev`. WAIT reacts only to cc_rise, never to a stale level.
- States: IDLE, ARM, WAIT, GO, LOAD, RESULT, EARLY, DONE. Moore outputs are decoded from the registered state.
- IDLE: press goes to ARM.
- ARM: oStart_down_count = 1. An arm counter runs ARM_CYCLES cycles, then goes to WAIT. A press goes to EARLY.
- WAIT: press goes to EARLY; otherwise cc_rise goes to GO.
- GO: oStart_up_count = 0. Press goes to LOAD. Otherwise iUpCount ≥ TIMEOUT_MS goes to RESULT with the timeout flag set and round +1.
- LOAD: oLoad_score = 1 for exactly one cycle, round +1, then RESULT unconditionally. oStart_up_count stays 0 so iUpCount is frozen across the load edge.
- RESULT: a hold counter runs HOLD_CYCLES. Presses before expiry are ignored. After expiry a press goes to DONE if oRound == NUM_ROUNDS, else to ARM and clears the timeout flag.
- EARLY: same hold rule, then a press goes to ARM. The round does not increment.
- DONE: press goes to IDLE and clears oRound.
- oStart_up_count = 1 in every state except GO and LOAD.
- oStart_down_count = 1 only in ARM.
- oScreen mapping:
  - IDLE, DONE: 0
  - ARM, WAIT: 1
  - GO, LOAD: 2
  - RESULT, EARLY: 3
- Hold and arm counters reload on every state entry.
- oRound saturates at 7.

## Timing
- Reset values:
  - State: IDLE
  - oStart_down_count 0, oStart_up_count 1, oLoad_score 0
  - oScreen 0, oEarly 0, oTimeout 0, oRound 0, oDone 0
  - Synchronizer and prev registers 0; cc prev register 1
- Reset mid-operation returns to IDLE at the next edge regardless of state. No load pulse is emitted.
- Press latency: iButton first sampled high at edge N; the state and outputs change at edge N+2.
- cc_rise latency: iCountComplete sampled high at edge N (prev 0); GO is entered at edge N+1.
- ARM lasts exactly ARM_CYCLES cycles without a press.
- RESULT/EARLY ignore presses during their first HOLD_CYCLES cycles.
- Simultaneous events:
  - In WAIT, press and cc_rise in the same cycle go to EARLY.
  - In GO, press and timeout in the same cycle go to LOAD.
  - In ARM, press and arm expiry in the same cycle go to EARLY.
- oLoad_score is never high for two consecutive cycles and is high only in LOAD.

## Test plan
Bench parameters: ARM_CYCLES=3, HOLD_CYCLES=4, TIMEOUT_MS=100, NUM_ROUNDS=2.
- Normal round: press in IDLE, then oStart_down_count high for 3 cycles. Pulse iCountComplete gives oScreen=2, oStart_up_count=0. Press at iUpCount=250 gives one oLoad_score pulse, then RESULT with oScreen=3, oRound=1, oTimeout=0.
- False start: press during WAIT gives oEarly=1, oScreen=3, no load pulse, oRound unchanged. A press before 4 hold cycles is ignored; a press after goes to ARM.
- Timeout: in GO drive iUpCount=100 with no press; RESULT is entered with oTimeout=1, oRound+1, oLoad_score never high.
- Session end: complete 2 rounds, then a press after hold gives oDone=1, oScreen=0. A further press gives IDLE with oRound=0.
- Ties: press and cc_rise in the same WAIT cycle give EARLY. Press and iUpCount=100 in the same GO cycle give LOAD.
- Reset: assert iReset in GO with iUpCount=50; the next edge gives IDLE and every output at its reset value. iCountComplete held high after reset does not trigger GO without a new rising edge.

Source files
------------

// File: rtl/reaction_controller_if.sv
// Signals between the reaction sequencer, the player button and the reaction datapath.
// The master modport is the controller side; the slave modport is the button/datapath side.
interface reaction_controller_if;
    logic        iButton;
    logic        iCountComplete;
    logic [11:0] iUpCount;
    logic        oStart_down_count;
    logic        oStart_up_count;
    logic        oLoad_score;
    logic [1:0]  oScreen;
    logic        oEarly;
    logic        oTimeout;
    logic [2:0]  oRound;
    logic        oDone;

    modport master (
        input  iButton, iCountComplete, iUpCount,
        output oStart_down_count, oStart_up_count, oLoad_score, oScreen,
        output oEarly, oTimeout, oRound, oDone
    );

    modport slave (
        output iButton, iCountComplete, iUpCount,
        input  oStart_down_count, oStart_up_count, oLoad_score, oScreen,
        input  oEarly, oTimeout, oRound, oDone
    );
endinterface

// File: rtl/reaction_controller.sv
// Reaction-time benchmark sequencer: arms the random delay, times the reaction, loads the score,
// flags false starts and timeouts, counts rounds and selects the display screen.
module reaction_controller #(
    parameter int unsigned ARM_CYCLES  = 50000,
    parameter int unsigned HOLD_CYCLES = 25000000,
    parameter int unsigned TIMEOUT_MS  = 2000,
    parameter int unsigned NUM_ROUNDS  = 5
) (
    input logic                  clk,
    input logic                  iReset,
    reaction_controller_if.master bus
);

    localparam logic [24:0] ArmLast    = 25'(ARM_CYCLES - 1);
    localparam logic [24:0] HoldLen    = 25'(HOLD_CYCLES);
    localparam logic [11:0] TimeoutVal = 12'(TIMEOUT_MS);
    localparam logic [2:0]  RoundsVal  = 3'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        StIdle, StArm, StWait, StGo, StLoad, StResult, StEarly, StDone
    } state_e;

    state_e      state_q, state_d;
    logic        btn_sync1_q, btn_sync2_q, btn_prev_q;
    logic        cc_sample_q, cc_prev_q;
    logic [24:0] cnt_q, cnt_d;
    logic [2:0]  round_q, round_d;
    logic        timeout_q, timeout_d;

    logic        press, cc_rise, arm_done, hold_done, up_expired;
    logic [2:0]  round_inc;

    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q     <= StIdle;
            btn_sync1_q <= 1'b0;
            btn_sync2_q <= 1'b0;
            btn_prev_q  <= 1'b0;
            // Both set so a flag already high when reset releases never reads as a new edge.
            cc_sample_q <= 1'b1;
            cc_prev_q   <= 1'b1;
            cnt_q       <= '0;
            round_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_sync1_q <= bus.iButton;
            btn_sync2_q <= btn_sync1_q;
            btn_prev_q  <= btn_sync2_q;
            cc_sample_q <= bus.iCountComplete;
            cc_prev_q   <= cc_sample_q;
            cnt_q       <= cnt_d;
            round_q     <= round_d;
            timeout_q   <= timeout_d;
        end
    end

    assign press      = btn_sync2_q & ~btn_prev_q;
    assign cc_rise    = cc_sample_q & ~cc_prev_q;
    assign arm_done   = (cnt_q == ArmLast);
    assign hold_done  = (cnt_q >= HoldLen);
    assign up_expired = (bus.iUpCount >= TimeoutVal);
    assign round_inc  = (round_q == 3'd7) ? round_q : round_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (press) state_d = StArm;
            end
            StArm: begin
                if (press)         state_d = StEarly;
                else if (arm_done) state_d = StWait;
            end
            StWait: begin
                if (press)        state_d = StEarly;
                else if (cc_rise) state_d = StGo;
            end
            StGo: begin
                if (press) begin
                    state_d = StLoad;
                end else if (up_expired) begin
                    state_d   = StResult;
                    timeout_d = 1'b1;
                    round_d   = round_inc;
                end
            end
            StLoad: begin
                state_d = StResult;
                round_d = round_inc;
            end
            StResult: begin
                if (hold_done && press) begin
                    state_d   = (round_q == RoundsVal) ? StDone : StArm;
                    timeout_d = 1'b0;
                end
            end
            StEarly: begin
                if (hold_done && press) state_d = StArm;
            end
            StDone: begin
                if (press) begin
                    state_d = StIdle;
                    round_d = '0;
                end
            end
        endcase
    end

    // One shared timer serves ARM and the RESULT/EARLY hold; it restarts on every state change.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 25'd1;
        end
    end

    always_comb begin
        bus.oStart_down_count = 1'b0;
        bus.oStart_up_count   = 1'b1;
        bus.oLoad_score       = 1'b0;
        bus.oScreen           = 2'd0;
        bus.oEarly            = 1'b0;
        bus.oDone             = 1'b0;
        bus.oTimeout          = timeout_q & (state_q == StResult);
        bus.oRound            = round_q;
        unique case (state_q)
            StIdle:   bus.oScreen = 2'd0;
            StArm: begin
                bus.oStart_down_count = 1'b1;
                bus.oScreen           = 2'd1;
            end
            StWait:   bus.oScreen = 2'd1;
            StGo: begin
                bus.oStart_up_count = 1'b0;
                bus.oScreen         = 2'd2;
            end
            StLoad: begin
                bus.oStart_up_count = 1'b0;
                bus.oLoad_score     = 1'b1;
                bus.oScreen         = 2'd2;
            end
            StResult: bus.oScreen = 2'd3;
            StEarly: begin
                bus.oScreen = 2'd3;
                bus.oEarly  = 1'b1;
            end
            StDone:   bus.oDone = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_reaction_controller.sv
// Directed-plus-random bench for reaction_controller; expectations come from a phase-level
// model of the game rules (round count, timeout flag, hold window, load-pulse count).
module tb_reaction_controller;

    localparam int unsigned ArmC    = 3;
    localparam int unsigned HoldC   = 4;
    localparam int unsigned TmoC    = 100;
    localparam int unsigned RoundsC = 2;

    typedef enum {PIdle, PArm, PWait, PGo, PLoad, PResult, PEarly, PDone} phase_e;
    localparam int KNormal  = 0;
    localparam int KTimeout = 1;
    localparam int KEarly   = 2;

    logic clk;
    logic iReset;
    reaction_controller_if bus ();

    reaction_controller #(
        .ARM_CYCLES (ArmC),
        .HOLD_CYCLES(HoldC),
        .TIMEOUT_MS (TmoC),
        .NUM_ROUNDS (RoundsC)
    ) dut (
        .clk   (clk),
        .iReset(iReset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int exp_round = 0;
    int exp_loads = 0;
    bit exp_to    = 1'b0;

    int load_total = 0;
    int load_dbl   = 0;
    bit load_prev  = 1'b0;

    // Load pulses are counted independently; two in a row is a protocol violation.
    always @(negedge clk) begin
        if (bus.oLoad_score === 1'b1) begin
            load_total <= load_total + 1;
            if (load_prev) load_dbl <= load_dbl + 1;
        end
        load_prev <= (bus.oLoad_score === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [10:0] observed();
        return {bus.oStart_down_count, bus.oStart_up_count, bus.oLoad_score, bus.oScreen,
                bus.oEarly, bus.oTimeout, bus.oRound, bus.oDone};
    endfunction

    // Screen/strobe table for each game phase.
    function automatic logic [10:0] expect_out(input phase_e ph, input int rnd, input bit to);
        logic       down, up, ld, early, tmo, done;
        logic [1:0] scr;
        down = 0; up = 1; ld = 0; early = 0; tmo = 0; done = 0; scr = 2'd0;
        case (ph)
            PArm:    begin down = 1; scr = 2'd1; end
            PWait:   scr = 2'd1;
            PGo:     begin up = 0; scr = 2'd2; end
            PLoad:   begin up = 0; ld = 1; scr = 2'd2; end
            PResult: begin scr = 2'd3; tmo = to; end
            PEarly:  begin scr = 2'd3; early = 1; end
            PDone:   done = 1;
            default: ;
        endcase
        return {down, up, ld, scr, early, tmo, 3'(rnd), done};
    endfunction

    task automatic chk_ph(input string tag, input phase_e ph);
        chk(tag, 32'(observed()), 32'(expect_out(ph, exp_round, exp_to)));
    endtask

    task automatic press();
        bus.iButton = 1'b1;
        tick();
        bus.iButton = 1'b0;
        tick();
        tick();
    endtask

    function automatic int bump(input int r);
        return (r >= 7) ? 7 : r + 1;
    endfunction

    // Plays one round from the first ARM cycle up to the state after the hold-window press.
    task automatic play_round(input int kind, input bit tie, input int offset, output phase_e nxt);
        phase_e ph;
        for (int i = 0; i < int'(ArmC); i++) begin
            chk_ph("arm_hold", PArm);
            tick();
        end
        chk_ph("arm_to_wait", PWait);
        repeat ($urandom_range(0, 3)) begin
            tick();
            chk_ph("wait_idle", PWait);
        end
        if (kind == KEarly) begin
            bus.iButton = 1'b1;
            tick();
            bus.iButton = 1'b0;
            bus.iCountComplete = tie;
            tick();
            chk_ph("early_latency", PWait);
            bus.iCountComplete = 1'b0;
            tick();
            ph = PEarly;
        end else begin
            bus.iCountComplete = 1'b1;
            tick();
            bus.iCountComplete = 1'b0;
            chk_ph("cc_latency", PWait);
            tick();
            chk_ph("go_entry", PGo);
            bus.iUpCount = 12'($urandom_range(0, TmoC - 1));
            if (kind == KNormal) begin
                bus.iButton = 1'b1;
                tick();
                bus.iButton = 1'b0;
                chk_ph("go_press1", PGo);
                tick();
                chk_ph("go_press2", PGo);
                bus.iUpCount = tie ? 12'd250 : 12'($urandom_range(0, TmoC - 1));
                tick();
                chk_ph("load", PLoad);
                tick();
                exp_round = bump(exp_round);
                exp_loads++;
            end else begin
                repeat ($urandom_range(1, 3)) begin
                    tick();
                    chk_ph("go_count", PGo);
                end
                bus.iUpCount = 12'($urandom_range(TmoC, 4095));
                tick();
                exp_round = bump(exp_round);
                exp_to    = 1'b1;
            end
            ph = PResult;
        end
        bus.iUpCount = 12'd0;
        chk_ph("result_entry", ph);
        chk("load_count", 32'(load_total), 32'(exp_loads));
        repeat (offset) begin
            tick();
            chk_ph("hold_wait", ph);
        end
        press();
        // A press first seen at hold-count offset+2 is accepted only once the window has elapsed.
        if (offset + 2 < int'(HoldC)) begin
            chk_ph("hold_ignore", ph);
            repeat ($urandom_range(0, 2)) tick();
            press();
        end
        if (ph == PEarly) begin
            nxt = PArm;
        end else begin
            nxt    = (exp_round == int'(RoundsC)) ? PDone : PArm;
            exp_to = 1'b0;
        end
        chk_ph("hold_accept", nxt);
    endtask

    phase_e cur;
    int     iter;

    initial begin
        iReset = 1'b1;
        bus.iButton = 1'b0;
        bus.iCountComplete = 1'b0;
        bus.iUpCount = 12'd0;
        tick();
        tick();
        chk_ph("reset_state", PIdle);
        iReset = 1'b0;
        tick();

        // Session 1: directed normal (with timeout tie), false start, timeout, done.
        bus.iButton = 1'b1;
        tick();
        bus.iButton = 1'b0;
        tick();
        chk_ph("press_latency", PIdle);
        tick();
        play_round(KNormal, 1'b1, 1, cur);
        play_round(KEarly, 1'b0, 2, cur);
        play_round(KTimeout, 1'b0, $urandom_range(0, 3), cur);
        chk_ph("session1_done", PDone);
        press();
        exp_round = 0;
        chk_ph("done_to_idle", PIdle);

        // Session 2: random rounds, opening with a press/cc tie in WAIT.
        press();
        chk_ph("session2_arm", PArm);
        play_round(KEarly, 1'b1, $urandom_range(0, 3), cur);
        iter = 0;
        while (cur != PDone && iter < 40) begin
            play_round($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 3), cur);
            iter++;
        end
        chk_ph("session2_done", PDone);
        press();
        exp_round = 0;
        chk_ph("session2_idle", PIdle);

        // Session 3: reset while in GO, then a stale completion flag.
        press();
        play_round(KNormal, 1'b0, 3, cur);
        repeat (ArmC) tick();
        chk_ph("s3_wait", PWait);
        bus.iCountComplete = 1'b1;
        tick();
        bus.iCountComplete = 1'b0;
        tick();
        bus.iUpCount = 12'd50;
        tick();
        chk_ph("s3_go", PGo);
        iReset = 1'b1;
        bus.iCountComplete = 1'b1;
        tick();
        exp_round = 0;
        exp_to    = 1'b0;
        chk_ph("reset_in_go", PIdle);
        iReset = 1'b0;
        bus.iUpCount = 12'd0;
        tick();
        chk_ph("post_reset_idle", PIdle);
        press();
        repeat (ArmC) tick();
        chk_ph("stale_wait_entry", PWait);
        repeat (4) begin
            tick();
            chk_ph("cc_stale", PWait);
        end
        bus.iCountComplete = 1'b0;
        tick();
        bus.iCountComplete = 1'b1;
        tick();
        chk_ph("cc_fresh_latency", PWait);
        tick();
        chk_ph("cc_fresh", PGo);
        bus.iCountComplete = 1'b0;

        chk("load_total", 32'(load_total), 32'(exp_loads));
        chk("load_double", 32'(load_dbl), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
